regfile_sb: RTL and testbench

- General-purpose register file with a per-register busy scoreboard. It is the write-back consumer for the MEM/WB stage output (we/waddr/wdata).
- It serves two combinational read ports to the ID stage, with same-cycle write-to-read bypass.
- It tracks registers whose in-flight producer (load) has not yet written back, and raises stallreq to the stall controller when ID reads such a register.

---
 rtl/regfile_sb.sv | 135 +++++++++++++
 tb/tb_regfile_sb.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: general-purpose register file with a per-register busy scoreboard.
// Two combinational read ports with same-cycle write-back bypass, one write
// port fed from MEM/WB, and a pending-producer scoreboard that raises stallreq
// when ID reads a register whose load has not yet written back.
module regfile_sb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NREG   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re1,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic              re2,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2,
   input  logic              set_busy,
   input  logic [ADDR_W-1:0] busy_addr,
   input  logic              flush,
   output logic              stallreq,
   output logic [NREG-1:0]   busy_vec
);

   localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
   localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

   logic [DATA_W-1:0] regs_r [NREG];
   logic [NREG-1:0]   busy_r;
   logic [NREG-1:0]   busy_nxt_s;
   logic              haz1_s;
   logic              haz2_s;

   // Read mux for one port: disabled or x0 reads zero, a matching write-back
   // is forwarded in the same cycle, otherwise storage is returned.
   function automatic logic [DATA_W-1:0] read_mux(
      input logic              en,
      input logic [ADDR_W-1:0] addr,
      input logic              wr_en,
      input logic [ADDR_W-1:0] wr_addr,
      input logic [DATA_W-1:0] wr_data,
      input logic [DATA_W-1:0] stored
   );
      logic [DATA_W-1:0] res;
      if (!en) begin
         res = ZERO_DATA;
      end else if (addr == ZERO_ADDR) begin
         res = ZERO_DATA;
      end else if (wr_en && (wr_addr == addr)) begin
         res = wr_data;
      end else begin
         res = stored;
      end
      return res;
   endfunction

   // Hazard for one port: reading a pending register, unless the pending
   // value is arriving on the write-back port this very cycle.
   function automatic logic read_hazard(
      input logic              en,
      input logic [ADDR_W-1:0] addr,
      input logic              busy_bit,
      input logic              wr_en,
      input logic [ADDR_W-1:0] wr_addr
   );
      logic res;
      if (en && (addr != ZERO_ADDR) && busy_bit) begin
         res = !(wr_en && (wr_addr == addr));
      end else begin
         res = 1'b0;
      end
      return res;
   endfunction

   // Register storage: reset clears everything, x0 writes are dropped, rdy
   // low freezes the array.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_r[i] <= ZERO_DATA;
         end
      end else if (rdy && we && (waddr != ZERO_ADDR)) begin
         regs_r[waddr] <= wdata;
      end else begin
         regs_r[0] <= ZERO_DATA;
      end
   end

   // Scoreboard next state: flush beats set beats clear; a new producer
   // supersedes a retiring one on the same register.
   always_comb begin
      busy_nxt_s = busy_r;
      if (flush) begin
         busy_nxt_s = {NREG{1'b0}};
      end else begin
         if (we) begin
            busy_nxt_s[waddr] = 1'b0;
         end else begin
            busy_nxt_s = busy_nxt_s;
         end
         if (set_busy) begin
            busy_nxt_s[busy_addr] = 1'b1;
         end else begin
            busy_nxt_s = busy_nxt_s;
         end
      end
      busy_nxt_s[0] = 1'b0;
   end

   // Scoreboard register: updates only while rdy is high.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r <= {NREG{1'b0}};
      end else if (rdy) begin
         busy_r <= busy_nxt_s;
      end else begin
         busy_r <= busy_r;
      end
   end

   // Read ports and hazard detection; live regardless of rdy and flush.
   always_comb begin
      rdata1   = read_mux(re1, raddr1, we, waddr, wdata, regs_r[raddr1]);
      rdata2   = read_mux(re2, raddr2, we, waddr, wdata, regs_r[raddr2]);
      haz1_s   = read_hazard(re1, raddr1, busy_r[raddr1], we, waddr);
      haz2_s   = read_hazard(re2, raddr2, busy_r[raddr2], we, waddr);
      stallreq = haz1_s || haz2_s;
      busy_vec = busy_r;
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed table-driven bench for regfile_sb plus a hand-written
// two-port hazard sequence.
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        rst, rdy, we, re1, re2, set_busy, flush;
   logic [4:0]  waddr, raddr1, raddr2, busy_addr;
   logic [31:0] wdata;
   logic [31:0] rdata1, rdata2, busy_vec;
   logic        stallreq;

   int total = 0;
   int bad   = 0;

   regfile_sb dut (
      .clk(clk), .rst(rst), .rdy(rdy), .we(we), .waddr(waddr), .wdata(wdata),
      .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
      .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
      .set_busy(set_busy), .busy_addr(busy_addr), .flush(flush),
      .stallreq(stallreq), .busy_vec(busy_vec)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        rst;
      logic        rdy;
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        re1;
      logic [4:0]  ra1;
      logic        re2;
      logic [4:0]  ra2;
      logic        sb;
      logic [4:0]  ba;
      logic        fl;
      logic [31:0] e1;
      logic [31:0] e2;
      logic        est;
      logic [31:0] ebusy;
   } vec_t;

   function automatic vec_t v(
      input logic r, input logic rd, input logic w, input logic [4:0] wa,
      input logic [31:0] wd, input logic r1, input logic [4:0] a1,
      input logic r2, input logic [4:0] a2, input logic s, input logic [4:0] b,
      input logic f, input logic [31:0] x1, input logic [31:0] x2,
      input logic st, input logic [31:0] bv);
      vec_t t;
      t.rst = r; t.rdy = rd; t.we = w; t.waddr = wa; t.wdata = wd;
      t.re1 = r1; t.ra1 = a1; t.re2 = r2; t.ra2 = a2;
      t.sb = s; t.ba = b; t.fl = f;
      t.e1 = x1; t.e2 = x2; t.est = st; t.ebusy = bv;
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      rst = t.rst; rdy = t.rdy; we = t.we; waddr = t.waddr; wdata = t.wdata;
      re1 = t.re1; raddr1 = t.ra1; re2 = t.re2; raddr2 = t.ra2;
      set_busy = t.sb; busy_addr = t.ba; flush = t.fl;
   endtask

   task automatic expect_out(input int idx, input logic [31:0] x1, input logic [31:0] x2,
                             input logic st, input logic [31:0] bv);
      check($sformatf("row%0d_rdata1", idx), rdata1, x1);
      check($sformatf("row%0d_rdata2", idx), rdata2, x2);
      check($sformatf("row%0d_stallreq", idx), {31'd0, stallreq}, {31'd0, st});
      check($sformatf("row%0d_busy_vec", idx), busy_vec, bv);
   endtask

   vec_t tbl [23];

   initial begin
      //            rst  rdy  we   waddr  wdata          re1  ra1   re2  ra2   sb   ba    fl   e1             e2            st   busy
      tbl[0]  = v(1'b1,1'b1,1'b0,5'd0, 32'h0,        1'b1,5'd5, 1'b0,5'd0, 1'b0,5'd0, 1'b0,32'h0,        32'h0,       1'b0,32'h0);
      tbl[1]  = v(1'b0,1'b1,1'b1,5'd5, 32'hDEADBEEF, 1'b1,5'd5, 1'b1,5'd0, 1'b0,5'd0, 1'b0,32'hDEADBEEF, 32'h0,       1'b0,32'h0);
      tbl[2]  = v(1'b0,1'b1,1'b0,5'd0, 32'h0,        1'b1,5'd5, 1'b1,5'd0, 1'b0,5'd0, 1'b0,32'hDEADBEEF, 32'h0,       1'b0,32'h0);
      tbl[3]  = v(1'b0,1'b1,1'b1,5'd0, 32'h12345678, 1'b1,5'd0, 1'b1,5'd0, 1'b0,5'd0, 1'b0,32'h0,        32'h0,       1'b0,32'h0);
      tbl[4]  = v(1'b0,1'b1,1'b0,5'd0, 32'h0,        1'b0,5'd5, 1'b1,5'd0, 1'b0,5'd0, 1'b0,32'h0,        32'h0,       1'b0,32'h0);
      tbl[5]  = v(1'b0,1'b1,1'b1,5'd7, 32'h1,        1'b1,5'd5, 1'b0,5'd0, 1'b0,5'd0, 1'b0,32'hDEADBEEF, 32'h0,       1'b0,32'h0);
      tbl[6]  = v(1'b0,1'b1,1'b1,5'd7, 32'h2,        1'b1,5'd7, 1'b1,5'd7, 1'b0,5'd0, 1'b0,32'h2,        32'h2,       1'b0,32'h0);
      tbl[7]  = v(1'b0,1'b1,1'b0,5'd0, 32'h0,        1'b1,5'd7, 1'b1,5'd7, 1'b0,5'd0, 1'b0,32'h2,        32'h2,       1'b0,32'h0);
      tbl[8]  = v(1'b0,1'b1,1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0,5'd0, 1'b1,5'd3, 1'b0,32'h0,        32'h0,       1'b0,32'h0);
      tbl[9]  = v(1'b0,1'b1,1'b0,5'd0, 32'h0,        1'b1,5'd3, 1'b0,5'd0, 1'b0,5'd0, 1'b0,32'h0,        32'h0,       1'b1,32'h8);
      tbl[10] = v(1'b0,1'b1,1'b1,5'd3, 32'hAA,       1'b1,5'd3, 1'b0,5'd0, 1'b0,5'd0, 1'b0,32'hAA,       32'h0,       1'b0,32'h8);
      tbl[11] = v(1'b0,1'b1,1'b0,5'd0, 32'h0,        1'b1,5'd3, 1'b0,5'd0, 1'b0,5'd0, 1'b0,32'hAA,       32'h0,       1'b0,32'h0);
      tbl[12] = v(1'b0,1'b1,1'b1,5'd4, 32'h44,       1'b0,5'd0, 1'b1,5'd4, 1'b1,5'd4, 1'b0,32'h0,        32'h44,      1'b0,32'h0);
      tbl[13] = v(1'b0,1'b1,1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b1,5'd4, 1'b0,5'd0, 1'b0,32'h0,        32'h44,      1'b1,32'h10);
      tbl[14] = v(1'b0,1'b1,1'b1,5'd4, 32'h4545,     1'b0,5'd0, 1'b1,5'd4, 1'b1,5'd4, 1'b1,32'h0,        32'h4545,    1'b0,32'h10);
      tbl[15] = v(1'b0,1'b1,1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b1,5'd4, 1'b0,5'd0, 1'b0,32'h0,        32'h4545,    1'b0,32'h0);
      tbl[16] = v(1'b0,1'b0,1'b1,5'd9, 32'h55,       1'b1,5'd9, 1'b0,5'd0, 1'b1,5'd10,1'b0,32'h55,       32'h0,       1'b0,32'h0);
      tbl[17] = v(1'b0,1'b1,1'b0,5'd0, 32'h0,        1'b1,5'd9, 1'b1,5'd10,1'b0,5'd0, 1'b0,32'h0,        32'h0,       1'b0,32'h0);
      tbl[18] = v(1'b0,1'b1,1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0,5'd0, 1'b1,5'd10,1'b0,32'h0,        32'h0,       1'b0,32'h0);
      tbl[19] = v(1'b0,1'b0,1'b0,5'd0, 32'h0,        1'b1,5'd10,1'b0,5'd0, 1'b0,5'd0, 1'b1,32'h0,        32'h0,       1'b1,32'h400);
      tbl[20] = v(1'b0,1'b1,1'b0,5'd0, 32'h0,        1'b1,5'd10,1'b0,5'd0, 1'b0,5'd0, 1'b0,32'h0,        32'h0,       1'b1,32'h400);
      tbl[21] = v(1'b1,1'b1,1'b0,5'd0, 32'h0,        1'b1,5'd5, 1'b1,5'd10,1'b0,5'd0, 1'b0,32'hDEADBEEF, 32'h0,       1'b1,32'h400);
      tbl[22] = v(1'b0,1'b1,1'b0,5'd0, 32'h0,        1'b1,5'd5, 1'b1,5'd7, 1'b0,5'd0, 1'b0,32'h0,        32'h0,       1'b0,32'h0);

      // Initial reset edge so storage is defined before the table starts.
      drive(tbl[0]);
      @(posedge clk); #1;

      for (int i = 0; i < 23; i++) begin
         drive(tbl[i]);
         @(negedge clk);
         expect_out(i, tbl[i].e1, tbl[i].e2, tbl[i].est, tbl[i].ebusy);
         @(posedge clk); #1;
      end

      // Two pending registers; retiring one of them still leaves a hazard
      // on the other port, then retiring the second clears everything.
      drive(v(1'b0,1'b1,1'b0,5'd0,32'h0, 1'b0,5'd0, 1'b0,5'd0, 1'b1,5'd12, 1'b0, 32'h0,32'h0,1'b0,32'h0));
      @(posedge clk); #1;
      drive(v(1'b0,1'b1,1'b0,5'd0,32'h0, 1'b0,5'd0, 1'b0,5'd0, 1'b1,5'd13, 1'b0, 32'h0,32'h0,1'b0,32'h0));
      @(negedge clk);
      expect_out(100, 32'h0, 32'h0, 1'b0, 32'h1000);
      @(posedge clk); #1;
      drive(v(1'b0,1'b1,1'b1,5'd12,32'hC0FFEE, 1'b1,5'd12, 1'b1,5'd13, 1'b0,5'd0, 1'b0, 32'h0,32'h0,1'b0,32'h0));
      @(negedge clk);
      expect_out(101, 32'hC0FFEE, 32'h0, 1'b1, 32'h3000);
      @(posedge clk); #1;
      drive(v(1'b0,1'b1,1'b1,5'd13,32'h1313, 1'b1,5'd12, 1'b1,5'd13, 1'b0,5'd0, 1'b0, 32'h0,32'h0,1'b0,32'h0));
      @(negedge clk);
      expect_out(102, 32'hC0FFEE, 32'h1313, 1'b0, 32'h2000);
      @(posedge clk); #1;
      drive(v(1'b0,1'b1,1'b0,5'd0,32'h0, 1'b1,5'd12, 1'b1,5'd13, 1'b0,5'd0, 1'b0, 32'h0,32'h0,1'b0,32'h0));
      @(negedge clk);
      expect_out(103, 32'hC0FFEE, 32'h1313, 1'b0, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
